// File: rtl/fa_4bit_adder_pkg.sv
// fa_4bit_adder_pkg: shared adder width constant
package fa_4bit_adder_pkg;
  localparam int W = 4;
endpackage

// File: rtl/fa_4bit_adder_fa_1bit.sv
// fa_1bit: single-bit full adder; in a, b, cin; out s, cout
module fa_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/fa_4bit_adder.sv
// fa_4bit_adder: 4-bit ripple adder; in clk, rst, a, b, cin; out sum/cout (comb), sum_q/cout_q/ovf_q (registered, async reset)
module fa_4bit_adder
  import fa_4bit_adder_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [W-1:0] sum_q,
  output logic         cout_q,
  output logic         ovf_q
);
  logic [W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_bit
    fa_1bit u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .s(sum[i]), .cout(c[i+1]));
  end
  assign cout = c[W];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= c[W];
      ovf_q  <= c[W-1] ^ c[W];
    end
endmodule

// File: tb/tb_fa_4bit_adder.sv
// tb_fa_4bit_adder: scoreboard bench for fa_4bit_adder
module tb_fa_4bit_adder;
  logic clk = 1'b0, rst = 1'b1, cin = 1'b0, vld = 1'b0;
  logic [3:0] a = '0, b = '0, sum, sum_q;
  logic cout, cout_q, ovf_q;
  int total = 0, bad = 0;
  typedef struct {
    logic [3:0] s;
    logic c;
    logic o;
  } exp_t;
  exp_t sb[$];
  fa_4bit_adder dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .sum_q(sum_q), .cout_q(cout_q), .ovf_q(ovf_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask
  task automatic apply(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       input logic [3:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = ta; b = tb; cin = tc; vld = 1'b1;
    #1;
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    sb.push_back('{es, ec, eo});
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    if (vld && !rst) begin
      #1;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sum_q", 32'(sum_q), 32'(e.s));
        chk("cout_q", 32'(cout_q), 32'(e.c));
        chk("ovf_q", 32'(ovf_q), 32'(e.o));
      end
    end
  end
  initial begin
    logic [3:0] ta, tb, es;
    logic tc, ec, eo;
    logic [8:0] v;
    int r;
    #1;
    chk("rst_sum_q", 32'(sum_q), 0);
    chk("rst_cout_q", 32'(cout_q), 0);
    chk("rst_ovf_q", 32'(ovf_q), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(4'b1001, 4'b0010, 1'b0, 4'b1011, 1'b0, 1'b0);
    apply(4'b1100, 4'b0110, 1'b1, 4'b0011, 1'b1, 1'b0);
    apply(4'b1000, 4'b0110, 1'b1, 4'b1111, 1'b0, 1'b0);
    apply(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
    apply(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    apply(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
    apply(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    apply(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1);
    @(negedge clk);
    vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sum_q", 32'(sum_q), 0);
    chk("async_rst_cout_q", 32'(cout_q), 0);
    chk("async_rst_ovf_q", 32'(ovf_q), 0);
    a = 4'b1010; b = 4'b1011; cin = 1'b1;
    #1;
    chk("rst_comb_sum", 32'(sum), 32'h6);
    chk("rst_comb_cout", 32'(cout), 1);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold_sum_q", 32'(sum_q), 0);
      chk("rst_hold_cout_q", 32'(cout_q), 0);
      chk("rst_hold_ovf_q", 32'(ovf_q), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(4'b1010, 4'b1011, 1'b1, 4'b0110, 1'b1, 1'b1);
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      {ta, tb, tc} = v;
      r = 32'(ta) + 32'(tb) + 32'(tc);
      es = r[3:0];
      ec = r[4];
      eo = (ta[3] == tb[3]) && (es[3] != ta[3]);
      apply(ta, tb, tc, es, ec, eo);
    end
    @(negedge clk);
    vld = 1'b0;
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
